// File: rtl/pipeline_pkg.sv
// Shared definitions for the 16-bit, 8-register, 5-stage pipeline:
// ISA opcodes, forwarding-select encodings and operand-usage decode.
package pipeline_pkg;

    localparam int unsigned REG_W  = 3;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned FWD_W  = 2;
    localparam int unsigned CNT_W  = 16;

    localparam logic [OP_W-1:0] OP_AND  = 4'd0;
    localparam logic [OP_W-1:0] OP_ADD  = 4'd1;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd2;
    localparam logic [OP_W-1:0] OP_ADDI = 4'd3;
    localparam logic [OP_W-1:0] OP_ANDI = 4'd4;
    localparam logic [OP_W-1:0] OP_LW   = 4'd5;
    localparam logic [OP_W-1:0] OP_LB   = 4'd6;
    localparam logic [OP_W-1:0] OP_SW   = 4'd7;
    localparam logic [OP_W-1:0] OP_BGT  = 4'd8;
    localparam logic [OP_W-1:0] OP_BLT  = 4'd9;
    localparam logic [OP_W-1:0] OP_BEQ  = 4'd10;
    localparam logic [OP_W-1:0] OP_BNE  = 4'd11;
    localparam logic [OP_W-1:0] OP_JMP  = 4'd12;
    localparam logic [OP_W-1:0] OP_CALL = 4'd13;
    localparam logic [OP_W-1:0] OP_RET  = 4'd14;
    localparam logic [OP_W-1:0] OP_SV   = 4'd15;

    localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
    localparam logic [FWD_W-1:0] FWD_EX  = 2'b01;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b11;

    // Jumps, calls and returns read no general-purpose register.
    function automatic logic uses_rs1(input logic [OP_W-1:0] op);
        case (op)
            OP_JMP, OP_CALL, OP_RET: uses_rs1 = 1'b0;
            default:                 uses_rs1 = 1'b1;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [OP_W-1:0] op);
        case (op)
            OP_AND, OP_ADD, OP_SUB, OP_SW,
            OP_BGT, OP_BLT, OP_BEQ, OP_BNE: uses_rs2 = 1'b1;
            default:                        uses_rs2 = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Per-operand comparator: picks the youngest in-flight producer of one source
// register and flags a hit in EX for load-use detection.
module hazard_src_match
    import pipeline_pkg::*;
(
    input  logic [2:0] src_i,
    input  logic       used_i,
    input  logic [2:0] rd_ex_i,
    input  logic [2:0] rd_mem_i,
    input  logic [2:0] rd_wb_i,
    input  logic       regwr_ex_i,
    input  logic       regwr_mem_i,
    input  logic       regwr_wb_i,
    output logic [1:0] fwd_sel_o,
    output logic       ex_hit_o
);

    logic live;
    logic hit_ex;
    logic hit_mem;
    logic hit_wb;

    // R0 reads as zero, so it never needs a forwarded value.
    assign live    = used_i && (src_i != REG_W'(0));
    assign hit_ex  = live && regwr_ex_i  && (src_i == rd_ex_i);
    assign hit_mem = live && regwr_mem_i && (src_i == rd_mem_i);
    assign hit_wb  = live && regwr_wb_i  && (src_i == rd_wb_i);

    assign ex_hit_o = hit_ex;

    always_comb begin
        fwd_sel_o = FWD_RF;
        if (hit_ex) begin
            fwd_sel_o = FWD_EX;
        end else if (hit_mem) begin
            fwd_sel_o = FWD_MEM;
        end else if (hit_wb) begin
            fwd_sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_detect.sv
// ID-stage data-hazard unit: operand forwarding selects, load-use stall and a
// saturating stall-cycle counter.
module hazard_detect
    import pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  opCode,
    input  logic [2:0]  RS1,
    input  logic [2:0]  RS2,
    input  logic [2:0]  Rd2,
    input  logic [2:0]  Rd3,
    input  logic [2:0]  Rd4,
    input  logic        EX_RegWr,
    input  logic        MEM_RegWr,
    input  logic        WB_RegWr,
    input  logic        EX_MemRd,
    output logic        stall,
    output logic [1:0]  ForwardA,
    output logic [1:0]  ForwardB,
    output logic [15:0] stall_cycles
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              use_a;
    logic              use_b;
    logic [FWD_W-1:0]  sel_a;
    logic [FWD_W-1:0]  sel_b;
    logic              ex_hit_a;
    logic              ex_hit_b;
    logic              load_use;
    logic [CNT_W-1:0]  stall_cycles_d;
    logic [CNT_W-1:0]  stall_cycles_q;

    assign use_a = uses_rs1(opCode);
    assign use_b = uses_rs2(opCode);

    hazard_src_match u_match_a (
        .src_i       (RS1),
        .used_i      (use_a),
        .rd_ex_i     (Rd2),
        .rd_mem_i    (Rd3),
        .rd_wb_i     (Rd4),
        .regwr_ex_i  (EX_RegWr),
        .regwr_mem_i (MEM_RegWr),
        .regwr_wb_i  (WB_RegWr),
        .fwd_sel_o   (sel_a),
        .ex_hit_o    (ex_hit_a)
    );

    hazard_src_match u_match_b (
        .src_i       (RS2),
        .used_i      (use_b),
        .rd_ex_i     (Rd2),
        .rd_mem_i    (Rd3),
        .rd_wb_i     (Rd4),
        .regwr_ex_i  (EX_RegWr),
        .regwr_mem_i (MEM_RegWr),
        .regwr_wb_i  (WB_RegWr),
        .fwd_sel_o   (sel_b),
        .ex_hit_o    (ex_hit_b)
    );

    // A load in EX has no data yet; the bubble it forces makes forwarding moot.
    assign load_use = EX_MemRd && EX_RegWr && (ex_hit_a || ex_hit_b);

    always_comb begin
        stall    = 1'b0;
        ForwardA = FWD_RF;
        ForwardB = FWD_RF;
        if (!reset) begin
            stall = load_use;
            if (!load_use) begin
                ForwardA = sel_a;
                ForwardB = sel_b;
            end
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != CNT_MAX)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_detect.sv
// Directed self-checking bench for hazard_detect with hand-computed expectations.
module tb_hazard_detect;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  opCode = '0;
    logic [2:0]  RS1 = '0;
    logic [2:0]  RS2 = '0;
    logic [2:0]  Rd2 = '0;
    logic [2:0]  Rd3 = '0;
    logic [2:0]  Rd4 = '0;
    logic        EX_RegWr = 1'b0;
    logic        MEM_RegWr = 1'b0;
    logic        WB_RegWr = 1'b0;
    logic        EX_MemRd = 1'b0;
    logic        stall;
    logic [1:0]  ForwardA;
    logic [1:0]  ForwardB;
    logic [15:0] stall_cycles;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hazard_detect dut (
        .clk          (clk),
        .reset        (reset),
        .opCode       (opCode),
        .RS1          (RS1),
        .RS2          (RS2),
        .Rd2          (Rd2),
        .Rd3          (Rd3),
        .Rd4          (Rd4),
        .EX_RegWr     (EX_RegWr),
        .MEM_RegWr    (MEM_RegWr),
        .WB_RegWr     (WB_RegWr),
        .EX_MemRd     (EX_MemRd),
        .stall        (stall),
        .ForwardA     (ForwardA),
        .ForwardB     (ForwardB),
        .stall_cycles (stall_cycles)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply one ID/EX/MEM/WB snapshot at the falling edge, then settle.
    task automatic drive(input logic [3:0] op, input logic [2:0] r1, input logic [2:0] r2,
                         input logic [2:0] d2, input logic [2:0] d3, input logic [2:0] d4,
                         input logic exw, input logic memw, input logic wbw, input logic ld);
        @(negedge clk);
        opCode = op; RS1 = r1; RS2 = r2;
        Rd2 = d2; Rd3 = d3; Rd4 = d4;
        EX_RegWr = exw; MEM_RegWr = memw; WB_RegWr = wbw; EX_MemRd = ld;
        #1;
    endtask

    task automatic expect_out(input string tag, input logic s, input logic [1:0] fa, input logic [1:0] fb);
        check({tag, ".stall"}, 32'(stall), 32'(s));
        check({tag, ".fa"}, 32'(ForwardA), 32'(fa));
        check({tag, ".fb"}, 32'(ForwardB), 32'(fb));
    endtask

    initial begin
        // Under reset a load-use hazard plus WB match must be suppressed.
        drive(4'd2, 3'd5, 3'd1, 3'd5, 3'd0, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1);
        expect_out("reset", 1'b0, 2'b00, 2'b00);
        check("reset.cnt", 32'(stall_cycles), 32'd0);

        drive(4'd1, 3'd3, 3'd4, 3'd3, 3'd4, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        expect_out("add_ex_mem", 1'b0, 2'b01, 2'b10);

        // Load-use: SUB reads R5 while LW to R5 is in EX.
        drive(4'd2, 3'd5, 3'd1, 3'd5, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        expect_out("load_use", 1'b1, 2'b00, 2'b00);
        check("load_use.cnt0", 32'(stall_cycles), 32'd0);
        @(posedge clk); #1;
        check("load_use.cnt1", 32'(stall_cycles), 32'd1);
        drive(4'd2, 3'd5, 3'd1, 3'd0, 3'd5, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_out("after_bubble", 1'b0, 2'b10, 2'b00);
        @(posedge clk); #1;
        check("after_bubble.cnt", 32'(stall_cycles), 32'd1);

        drive(4'd10, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        expect_out("beq_all", 1'b0, 2'b01, 2'b01);

        drive(4'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        expect_out("addi_r0", 1'b0, 2'b00, 2'b00);
        drive(4'd12, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 1'b1, 1'b1, 1'b1, 1'b1);
        expect_out("jmp", 1'b0, 2'b00, 2'b00);
        drive(4'd3, 3'd1, 3'd6, 3'd6, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("addi_rs2", 1'b0, 2'b00, 2'b00);
        drive(4'd3, 3'd1, 3'd5, 3'd5, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        expect_out("addi_ld_rs2", 1'b0, 2'b00, 2'b00);

        drive(4'd0, 3'd7, 3'd0, 3'd0, 3'd0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("and_wb_off", 1'b0, 2'b00, 2'b00);
        drive(4'd0, 3'd7, 3'd0, 3'd0, 3'd0, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_out("and_wb_on", 1'b0, 2'b11, 2'b00);

        drive(4'd7, 3'd1, 3'd2, 3'd0, 3'd2, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0);
        expect_out("sw", 1'b0, 2'b11, 2'b10);
        drive(4'd15, 3'd1, 3'd2, 3'd0, 3'd2, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0);
        expect_out("sv", 1'b0, 2'b11, 2'b00);
        drive(4'd1, 3'd1, 3'd5, 3'd5, 3'd1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        expect_out("ld_rs2", 1'b1, 2'b00, 2'b00);
        drive(4'd1, 3'd4, 3'd4, 3'd4, 3'd4, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        expect_out("ld_noregwr", 1'b0, 2'b10, 2'b10);

        // Saturation: clear, then hold a stall past 0xFFFF edges.
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("sat.clr", 32'(stall_cycles), 32'd0);
        reset = 1'b0;
        drive(4'd2, 3'd5, 3'd1, 3'd5, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (70000) @(posedge clk);
        #1;
        check("sat.cnt", 32'(stall_cycles), 32'hFFFF);
        check("sat.stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        check("sat.hold", 32'(stall_cycles), 32'hFFFF);

        // Reset mid-stall acts before any clock edge.
        @(negedge clk);
        reset = 1'b1;
        #1;
        expect_out("mid_reset", 1'b0, 2'b00, 2'b00);
        check("mid_reset.cnt", 32'(stall_cycles), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("restart.stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        check("restart.cnt", 32'(stall_cycles), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_detect.md
# hazard_detect

Combinational data-hazard unit for the 16-bit, 8-register, 5-stage pipeline, sitting beside the ID stage. It compares the source registers of the instruction in ID against the destinations of instructions in EX, MEM and WB. It drives per-operand forwarding selects for the ID-stage operand muxes and a load-use stall to the control unit and PC control. A registered stall-cycle counter provides a performance and verification hook.

## Interface
No parameters; widths are fixed by the ISA.
- clk  in  1  pipeline clock; only the stall counter is clocked
- reset  in  1  asynchronous, active-high
- opCode  in  4  opcode of the instruction in ID
- RS1  in  3  first source register field of the ID instruction
- RS2  in  3  second source register field of the ID instruction
- Rd2  in  3  destination of the instruction in EX
- Rd3  in  3  destination of the instruction in MEM
- Rd4  in  3  destination of the instruction in WB
- EX_RegWr, MEM_RegWr, WB_RegWr  in  1 each  register-write enable of the EX, MEM and WB instructions
- EX_MemRd  in  1  the EX instruction is a load
- stall  out  1  hold PC and IF/ID, bubble EX
- ForwardA  out  2  operand A select
- ForwardB  out  2  operand B select
- stall_cycles  out  16  saturating count of cycles with stall=1

## Operation
- Forward encoding: 00 = register file; 01 = EX result (ALU result); 10 = MEM result; 11 = WB data bus.
- Source usage by opCode:
  - 0 AND, 1 ADD, 2 SUB: RS1 and RS2.
  - 3 ADDI, 4 ANDI, 5 LW, 6 LB: RS1 only.
  - 7 SW: RS1 (base) and RS2 (data).
  - 8 BGT, 9 BLT, 10 BEQ, 11 BNE: RS1 and RS2.
  - 12 JMP, 13 CALL, 14 RET: none.
  - 15 SV: RS1 only.
- Match rule for stage s and source r: source is used, r != 0 (R0 is hardwired zero), RegWr_s = 1, and r == Rd_s.
- Forward priority is EX > MEM > WB (youngest wins). No match gives 00.
- Forward A is derived from RS1; Forward B from RS2. An unused operand always gives 00.
- Load-use stall: stall = EX_MemRd & EX_RegWr & (EX match on any used source).
- When stall = 1, ForwardA = ForwardB = 00.
- While reset = 1: stall = 0, ForwardA = ForwardB = 00.
- stall_cycles: increments by 1 at each rising clk edge where stall = 1 and reset = 0. Saturates at 0xFFFF.

## Timing
- stall and ForwardA/B are purely combinational from the inputs, with zero latency, valid in the same cycle.
- stall_cycles is registered. It asynchronously clears to 0 on reset assertion and holds 0 while reset is high.
- A stall lasts one cycle. The next cycle's inputs carry a bubble in EX (EX_RegWr = 0), which releases the stall, and the load now sits in MEM, selecting 10. The block holds no state toward this.
- Same destination valid in EX and MEM simultaneously: select 01.
- Rd match with RegWr = 0: ignored.
- RS1 == RS2 with both matching: both selects are identical.
- Reset deasserted mid-stream: outputs follow inputs immediately; the counter restarts at 0.

## Structure
- Shared package pipeline_pkg holds:
  - opcode constants (OP_AND … OP_SV);
  - forward-select constants FWD_RF/FWD_EX/FWD_MEM/FWD_WB;
  - register-index width (3) and data width (16).
- One sub-module hazard_src_match, instantiated twice (A and B). Inputs: a source, a used flag and the three Rd/RegWr pairs. Outputs: the 2-bit select and the ex_hit flag.
- The top level holds the opcode usage decode, the stall logic and the counter.

## Test plan
- ADD (op 1) RS1=3, RS2=4; EX Rd2=3 RegWr=1, MEM Rd3=4 RegWr=1, no load -> ForwardA=01, ForwardB=10, stall=0.
- LW in EX (EX_MemRd=1, EX_RegWr=1, Rd2=5); ID SUB RS1=5 -> stall=1, ForwardA/B=00, stall_cycles +1 next edge. Next cycle EX bubble, Rd3=5 MEM_RegWr=1 -> stall=0, ForwardA=10.
- Rd2=Rd3=Rd4=2 all RegWr=1, ID BEQ RS1=2, RS2=2 -> ForwardA=ForwardB=01.
- R0 and unused operands: ADDI RS1=0 with Rd2=0 RegWr=1 -> 00. JMP with matches -> 00, no stall even with a load in EX. ADDI RS2=6 matching Rd2 -> ForwardB=00.
- RegWr gating: Rd4=7, WB_RegWr=0, AND RS1=7 -> 00; with WB_RegWr=1 -> 11.
- Counter: hold a stall condition for 70000 cycles -> stall_cycles=0xFFFF. Assert reset mid-stall -> stall=0 and counter=0 immediately, before any clk edge.
